// File: rtl/seg_pkg.sv
// Shared segment table and decoder state encoding, common to the encoder and decoder.
package seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  // Active-low abcdefg, bit 6 = a ... bit 0 = g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [NIBBLE_W-1:0] NIBBLE_BAD = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational lookup from an active-low segment code to a BCD digit.
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]    i_code,
  output logic [NIBBLE_W-1:0] o_digit_c,
  output logic                o_valid_c
);

  // A blank display reads back as zero and is not treated as an error.
  always_comb begin
    o_digit_c = NIBBLE_BAD;
    o_valid_c = 1'b0;
    case (i_code)
      SEG_0:     begin o_digit_c = 4'd0; o_valid_c = 1'b1; end
      SEG_1:     begin o_digit_c = 4'd1; o_valid_c = 1'b1; end
      SEG_2:     begin o_digit_c = 4'd2; o_valid_c = 1'b1; end
      SEG_3:     begin o_digit_c = 4'd3; o_valid_c = 1'b1; end
      SEG_4:     begin o_digit_c = 4'd4; o_valid_c = 1'b1; end
      SEG_5:     begin o_digit_c = 4'd5; o_valid_c = 1'b1; end
      SEG_6:     begin o_digit_c = 4'd6; o_valid_c = 1'b1; end
      SEG_7:     begin o_digit_c = 4'd7; o_valid_c = 1'b1; end
      SEG_8:     begin o_digit_c = 4'd8; o_valid_c = 1'b1; end
      SEG_9:     begin o_digit_c = 4'd9; o_valid_c = 1'b1; end
      SEG_BLANK: begin o_digit_c = 4'd0; o_valid_c = 1'b1; end
      default:   begin o_digit_c = NIBBLE_BAD; o_valid_c = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg_stream_decoder.sv
// Decodes a stream of segment codes and packs NUM_DIGITS BCD digits per frame,
// first accepted digit in the top nibble, presented on a valid/ready output.
module seg_stream_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic                    seg_valid,
  input  logic                    frame_start,
  output logic                    seg_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    bad_pattern
);

  localparam int unsigned W     = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_shift;
  logic [W-1:0]       w_shift_nxt;
  logic [W-1:0]       w_base_shift;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [CNT_W-1:0]   w_base_count;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_base_err;
  logic               r_seg_ready;
  logic               r_out_valid;
  logic [NIBBLE_W-1:0] w_digit;
  logic               w_code_ok;

  seg_to_bcd u_seg_to_bcd (
    .i_code    (seg_in),
    .o_digit_c (w_digit),
    .o_valid_c (w_code_ok)
  );

  // Next-state and frame-assembly logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_count_nxt  = r_count;
    w_err_nxt    = r_err;
    w_base_shift = r_shift;
    w_base_count = r_count;
    w_base_err   = r_err;
    case (r_state)
      COLLECT: begin
        if (seg_valid) begin
          // frame_start drops the partial frame before this beat is packed.
          if (frame_start) begin
            w_base_shift = '0;
            w_base_count = '0;
            w_base_err   = 1'b0;
          end
          w_shift_nxt = (w_base_shift << 4) | W'(w_digit);
          w_count_nxt = w_base_count + CNT_W'(1);
          w_err_nxt   = w_base_err | ~w_code_ok;
          if (w_count_nxt == CNT_W'(NUM_DIGITS)) begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = COLLECT;
          w_shift_nxt = '0;
          w_count_nxt = '0;
          w_err_nxt   = 1'b0;
        end
      end
    endcase
  end

  // Handshake flags are registered from the next state so both track r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= COLLECT;
      r_shift     <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_seg_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_count     <= w_count_nxt;
      r_err       <= w_err_nxt;
      r_seg_ready <= (w_state_nxt == COLLECT);
      r_out_valid <= (w_state_nxt == HOLD);
    end
  end

  assign seg_ready   = r_seg_ready;
  assign out_valid   = r_out_valid;
  assign bcd_out     = r_shift;
  assign bad_pattern = r_err;

endmodule

// File: doc/seg_stream_decoder.md
Name: seg_stream_decoder

Overview:
- Reverse path of the team's BCD-to-seven-segment encoder. Accepts a stream of active-low abcdefg segment codes over a valid/ready handshake.
- Decodes each code back to a BCD digit and packs NUM_DIGITS digits into one word, most significant digit first.
- Presents the packed word on an output valid/ready handshake. Used for display read-back and self-check against the encoder on the DE2 build.

Parameters:
- NUM_DIGITS, 4, digits per frame; legal range 1..8.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- seg_in  input  7  segment code, bit 6 = a … bit 0 = g; a segment is lit when its bit is 0.
- seg_valid  input  1  seg_in holds a code.
- frame_start  input  1  qualifies the beat as the first digit of a new frame.
- seg_ready  output  1  block can accept a beat.
- bcd_out  output  4*NUM_DIGITS  packed frame; the first accepted digit is in the top nibble.
- out_valid  output  1  bcd_out holds a complete frame.
- out_ready  input  1  consumer takes the frame.
- bad_pattern  output  1  at least one code in the presented frame was undecodable.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=COLLECT; shift register, digit count and error flag cleared.
  - out_valid=0, bcd_out=0, bad_pattern=0, seg_ready=1.
- Decode table (active-low abcdefg):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4.
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111 (blank) → 0, not an error.
  - Any other code → nibble 4'hF, and the frame error flag is set.
- States: COLLECT, HOLD.
- COLLECT:
  - seg_ready=1, out_valid=0.
  - A beat is accepted when seg_valid=1 and seg_ready=1.
  - On accept: the register shifts left 4 bits and the decoded nibble is inserted in the low nibble; count increments.
  - frame_start=1 on an accepted beat discards the partial frame (register, count and error flag cleared first). That beat becomes digit 0 of the new frame.
  - frame_start is ignored when seg_valid=0.
  - The accept that brings count to NUM_DIGITS moves the state to HOLD.
  - Latency: out_valid=1 in the cycle after the final accept. bcd_out and bad_pattern are registered at that edge.
- HOLD:
  - seg_ready=0, out_valid=1.
  - bcd_out and bad_pattern are stable until the handshake.
  - On out_valid=1 and out_ready=1: return to COLLECT; register, count and error flag cleared.
  - seg_ready=1 from the next cycle, giving one bubble per frame.
- bcd_out and bad_pattern remain readable while out_valid=0 but are meaningful only when out_valid=1.
- NUM_DIGITS=1: every accepted beat produces a frame.
- Count width: clog2(NUM_DIGITS+1). No wrap; the count never exceeds NUM_DIGITS.
- Reset asserted mid-frame or in HOLD: partial or pending frame is lost; no output pulse after release.
- seg_in and frame_start are don't-care when seg_valid=0.

Decomposition:
- Shared package seg_pkg:
  - segment constants SEG_0..SEG_9 and SEG_BLANK (7-bit, active-low abcdefg).
  - NIBBLE_BAD = 4'hF.
  - state encoding COLLECT/HOLD.
  - Shared with the existing encoder so both ends use one table.
- Sub-module seg_to_bcd (combinational):
  - input 7-bit code; outputs 4-bit digit and a valid flag.
  - Keeps the FSM/packing logic in seg_stream_decoder separate from the lookup.

Test Plan:
- Nominal frame: beats 1001111, 0010010, 0000110, 1001100, the first with frame_start=1, out_ready=1 → out_valid for one cycle, bcd_out=16'h1234, bad_pattern=0; seg_ready back to 1 the cycle after.
- Backpressure: same frame, out_ready=0 for 5 cycles → out_valid held, seg_ready=0, bcd_out steady at 16'h1234; out_ready=1 completes the handshake.
- Bad code: beats 1, 1111110, 3, 4 → bcd_out=16'h1F34, bad_pattern=1; the next clean frame 5,6,7,8 gives 16'h5678 with bad_pattern=0.
- Blank and restart:
  - 1111111, 1111111, 0000000, 0000100 → 16'h0089.
  - Then 5, 6, frame_start with 7, 8, 9, 0 → 16'h7890 (5 and 6 discarded).
- Reset mid-frame:
  - After 2 accepted beats, pulse rst low asynchronously → out_valid=0, bcd_out=0, seg_ready=1 immediately.
  - Then 4 fresh beats of 9 → 16'h9999.
- Gapped input: seg_valid toggling 1/0 every cycle across one frame of 2,0,2,4 → 16'h2024. No beat accepted while seg_valid=0.
